// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush controller for a five-stage MIPS pipeline.
// Every cycle it decides whether each pipeline latch loads, holds or takes a
// bubble. It arbitrates between cache misses, data waits, load-use hazards,
// taken branches and halt. It also keeps saturating debug counters and a
// data-wait watchdog.
module pipeline_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int DWAIT_MAX = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       dec_rs,
  input  logic [4:0]       dec_rt,
  input  logic             dec_use_rs,
  input  logic             dec_use_rt,
  input  logic             mem_pcsrc,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

  state_t      state;
  logic [15:0] dwait_cnt;
  logic [15:0] dwait_nxt;
  logic        dreq;
  logic        dstall;
  logic        lu_haz;
  logic        flush_fire;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Watchdog increment, also saturating so a very long wait cannot wrap.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  assign dreq      = mem_dREN | mem_dWEN;
  assign dstall    = dreq & ~dhit;
  assign lu_haz    = ex_memread & (ex_rt != 5'd0) &
                     ((dec_use_rs & (dec_rs == ex_rt)) | (dec_use_rt & (dec_rt == ex_rt)));
  assign dwait_nxt = sat_inc16(dwait_cnt);

  // Prioritised enable/flush decode; DWAIT behaves like RUN except that rule 2
  // keeps firing while the data access is still outstanding.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    flush_fire  = 1'b0;
    if ((state == HALTED) || wb_halt) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (dstall) begin
      // Freeze everything up to MEM, push a bubble into WB.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (mem_pcsrc) begin
      // Redirect: squash the three younger instructions, load the new PC.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      flush_fire  = 1'b1;
    end else if (lu_haz) begin
      // Hold PC and decode, inject a bubble into EX.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!ihit) begin
      // Fetch miss: hold PC, let the rest drain with a bubble behind it.
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  // Controller FSM with registered halted flag and data-wait watchdog.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= RUN;
      halted      <= 1'b0;
      mem_timeout <= 1'b0;
      dwait_cnt   <= 16'd0;
    end else begin
      case (state)
        RUN: begin
          dwait_cnt <= 16'd0;
          if (wb_halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (dstall) begin
            state <= DWAIT;
          end
        end
        DWAIT: begin
          dwait_cnt <= dwait_nxt;
          if (dwait_nxt >= 16'(DWAIT_MAX)) begin
            mem_timeout <= 1'b1;
          end
          if (wb_halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (dhit || !dreq) begin
            state <= RUN;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // Saturating debug counters for stall cycles and branch/jump flushes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state != HALTED) && !pc_en) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (flush_fire) begin
        flush_cnt <= sat_inc(flush_cnt);
      end
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. Each cycle it decides which of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB latches load, hold or take a bubble. It arbitrates between instruction-cache misses, data-cache waits, load-use hazards, taken branches/jumps and halt. It also keeps saturating stall/flush counters and a data-wait watchdog for debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush counters
- DWAIT_MAX, 255, data-wait cycles before mem_timeout is raised (1..2^16-1)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- ihit  in  1  instruction memory returned the fetch this cycle
- dhit  in  1  data memory completed the MEM-stage access this cycle
- mem_dREN  in  1  MEM-stage instruction is a load
- mem_dWEN  in  1  MEM-stage instruction is a store
- ex_memread  in  1  ID/EX holds a load
- ex_rt  in  5  destination register of the ID/EX load
- dec_rs, dec_rt  in  5 each  source registers of the instruction in decode
- dec_use_rs, dec_use_rt  in  1 each  decode actually reads rs / rt
- mem_pcsrc  in  1  branch taken or jump, resolved in MEM
- wb_halt  in  1  halt instruction in writeback
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch load enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble (NOP, zero controls)
- halted  out  1  sticky halt flag
- mem_timeout  out  1  sticky: data wait exceeded DWAIT_MAX
- stall_cnt  out  CNT_W  cycles with pc_en=0 outside HALTED, saturating
- flush_cnt  out  CNT_W  cycles with mem_pcsrc flush, saturating

## Operation
- FSM states: RUN, DWAIT, HALTED. Reset state is RUN.
- Definitions:
  - dreq = mem_dREN | mem_dWEN.
  - lu_haz = ex_memread & ex_rt≠0 & ((dec_use_rs & dec_rs==ex_rt) | (dec_use_rt & dec_rt==ex_rt)).
- Enables and flushes are combinational (Mealy) from state and inputs. Priority is highest first:
  1. HALTED, or wb_halt in RUN/DWAIT: all enables 0, all flushes 0.
  2. dreq & ~dhit (RUN or DWAIT): pc/ifid/idex/exmem en=0. memwb_en=1 and memwb_flush=1 (bubble into WB).
  3. mem_pcsrc: all enables 1; ifid_flush, idex_flush and exmem_flush=1. The new PC loads.
  4. lu_haz: pc_en=0, ifid_en=0. idex_en=1 with idex_flush=1. exmem_en=1, memwb_en=1.
  5. ~ihit: pc_en=0. ifid_en=1 with ifid_flush=1. Downstream enables 1.
  6. Otherwise all enables 1 and all flushes 0.
- Transitions:
  - RUN→HALTED on wb_halt; DWAIT→HALTED on wb_halt.
  - RUN→DWAIT on dreq & ~dhit.
  - DWAIT→RUN on dhit. That cycle is evaluated as if in RUN, so rules 3–6 apply.
  - DWAIT→RUN if dreq drops (defensive).
  - HALTED is terminal until RST.
- Watchdog:
  - dwait_cnt is 16-bit. It clears in RUN and increments each DWAIT cycle.
  - When dwait_cnt reaches DWAIT_MAX, mem_timeout sets. It stays set until RST.
  - The stall itself continues after mem_timeout sets.
- Counters:
  - stall_cnt increments on every non-HALTED cycle with pc_en=0, including wb_halt cycles.
  - flush_cnt increments when rule 3 fires.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (RST high, async): state=RUN, halted=0, mem_timeout=0, stall_cnt=0, flush_cnt=0, dwait_cnt=0.
- During reset the combinational outputs follow RUN with live inputs.
- Zero-cycle latency from hazard inputs to enables/flushes, same cycle.
- State, halted, mem_timeout and counters update on the CLK rising edge.
- halted rises one cycle after wb_halt is first seen.
- Load-use stall lasts exactly one cycle: the bubble clears ex_memread.
- dhit in the same cycle as a new dreq: no DWAIT entry and no stall.
- mem_pcsrc concurrent with a data wait: the flush is deferred (rule 2 wins). It applies on the dhit cycle because the MEM latch is held.
- lu_haz concurrent with mem_pcsrc: the flush wins, and the stalled decode instruction is discarded.
- RST mid-DWAIT: returns to RUN immediately, and counters clear.

## Test plan
- ihit=0 for 3 cycles, no other hazards → pc_en=0 and ifid_flush=1 for 3 cycles; stall_cnt=3.
- ex_memread=1, ex_rt=8, dec_rs=8, dec_use_rs=1 → one cycle with pc_en=0, ifid_en=0, idex_flush=1. Same stimulus with ex_rt=0 → no stall.
- mem_dREN=1, dhit low for 4 cycles then high → 4 cycles of memwb_flush=1 with upstream frozen; all enables 1 on the dhit cycle; state back to RUN.
- DWAIT_MAX=5, dhit held low → mem_timeout=1 after the 5th DWAIT cycle, and it stays 1 after dhit.
- mem_pcsrc=1 together with lu_haz → ifid/idex/exmem flush=1, pc_en=1, flush_cnt+1.
- wb_halt=1 → all enables 0 that cycle, halted=1 next cycle and held. Force stall_cnt to all-ones and stall → it stays saturated.
